kappa_mixer_chain: RTL and testbench
====================================

Name: kappa_mixer_chain

Overview:
Parametrised successor to the two-stage kappa mixer. A DEPTH-stage feedback buffer chain is combined through a run-time selectable operator and XOR-ed with the incoming word. The chain advances only on accepted valid/ready beats. The output is a registered stream, plus a beat counter and a synchronous flush, for use inside streaming datapaths.

Parameters:
WIDTH, 32, data width of input, buffers and output
DEPTH, 2, number of buffer stages; legal range 2..16; DEPTH=2 reproduces legacy kappa arithmetic
CNT_W, 16, width of accepted-beat counter

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept input beat
z_in  input  WIDTH  input data
mode  input  2  combine operator, kappa_mode_e, sampled on each accepted beat
flush  input  1  clear chain, counter and output register
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data
out_data  output  WIDTH  mixed result
beat_cnt  output  CNT_W  accepted beats since reset/flush, wraps
primed  output  1  at least DEPTH beats accepted since reset/flush

Behaviour:
- Reset: rst_n sampled on posedge clk only, low => all buf[i]=0, out_data=0, out_valid=0, beat_cnt=0, primed=0. in_ready=0 while rst_n low.
- accept = in_valid && in_ready; in_ready = rst_n && !flush && (!out_valid || out_ready).
- mixed = buf[DEPTH-2] OP buf[DEPTH-1]. OP: KAPPA_AND=0 AND, KAPPA_OR=1 OR, KAPPA_XOR=2 XOR, 3 reserved => AND.
- On accept, all from pre-edge values:
  - buf[0] <= z_in + mixed (mod 2^WIDTH, carry dropped)
  - buf[i] <= buf[i-1] | z_in for i=1..DEPTH-1
  - out_data <= mixed ^ z_in; out_valid <= 1
  - beat_cnt <= beat_cnt+1, wraps at 2^CNT_W
- Latency: one cycle, accept edge to out_valid/out_data.
- Output hold: out_valid && !out_ready => out_data, out_valid stable and in_ready=0.
- Output drain: out_ready && !accept => out_valid <= 0.
- Accept and drain in the same cycle => new word loaded, out_valid stays 1. Full throughput, 1 beat/cycle.
- No accept => buffers hold; z_in and mode ignored.
- primed: set on the edge where the accepted-beat count reaches DEPTH. Cleared only by reset/flush. It is not cleared by beat_cnt wrap.
- Flush (rst_n high, flush high at edge): buffers, out_data, out_valid, beat_cnt, primed <= 0. A pending output is discarded. in_ready=0 during flush, so no beat is lost silently.
- Priority: reset > flush > accept.
- Reset or flush mid-stream: next accepted beat behaves exactly as the first beat after reset.

Decomposition:
- Package kappa_pkg:
  - typedef enum logic [1:0] kappa_mode_e {KAPPA_AND, KAPPA_OR, KAPPA_XOR, KAPPA_RSVD}
  - localparam KAPPA_MAX_DEPTH=16
- Sub-module kappa_combine: purely combinational, WIDTH-parametrised; inputs a, b, mode; output op result (reserved => AND).
- Top holds the buffer array (generate loop), handshake, counter and flags. Elaborate-time assertion: 2 <= DEPTH <= KAPPA_MAX_DEPTH.

Test Plan:
- Legacy equivalence: WIDTH=8, DEPTH=2, mode=AND, out_ready=1, beats z=1,2,3 -> out_data 1,3,0; final buf0=6, buf1=3; primed after beat 2; beat_cnt=3.
- Depth generalisation: DEPTH=3, mode=OR, beats z=1,2 -> out_data 1,3; buf=(3,3,3); primed=0 until third beat accepted.
- Backpressure: out_ready=0, beat z=5 accepted -> out_valid=1, in_ready=0; hold z=9 valid 4 cycles -> out_data stays 5, buf unchanged. Raise out_ready -> z=9 accepted the same cycle, out_valid stays 1.
- Flush mid-stream: after 3 beats with out_valid=1, pulse flush with in_valid=1 -> in_ready=0 that cycle; next cycle out_valid=0, beat_cnt=0, primed=0. Replaying z=1,2,3 reproduces 1,3,0.
- Sync reset: drop rst_n between clock edges -> no state change until next posedge; then all outputs 0, in_ready=0 while low.
- Mode/counter: mode=3 gives the same results as AND. CNT_W=4, 17 beats -> beat_cnt=1, primed=1.

Source files
------------

// File: rtl/kappa_pkg.sv
// Shared types and limits for the kappa mixer family.
package kappa_pkg;

  typedef enum logic [1:0] {
    KAPPA_AND  = 2'd0,
    KAPPA_OR   = 2'd1,
    KAPPA_XOR  = 2'd2,
    KAPPA_RSVD = 2'd3
  } kappa_mode_e;

  localparam int unsigned KAPPA_MAX_DEPTH = 16;
  // Wide enough to count up to KAPPA_MAX_DEPTH regardless of CNT_W.
  localparam int unsigned KAPPA_PRIME_W   = $clog2(KAPPA_MAX_DEPTH + 1);

endpackage

// File: rtl/kappa_combine.sv
// Combinational operator between the two oldest chain stages; reserved mode acts as AND.
module kappa_combine
  import kappa_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  kappa_mode_e      mode,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = a & b;
    unique case (mode)
      KAPPA_AND:  y = a & b;
      KAPPA_OR:   y = a | b;
      KAPPA_XOR:  y = a ^ b;
      KAPPA_RSVD: y = a & b;
      default:    y = a & b;
    endcase
  end

endmodule

// File: rtl/kappa_mixer_chain.sv
// DEPTH-stage kappa feedback chain with registered valid/ready output, beat counter and flush.
module kappa_mixer_chain
  import kappa_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] z_in,
  input  logic [1:0]       mode,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             primed
);

  if (DEPTH < 2 || DEPTH > KAPPA_MAX_DEPTH) begin : g_bad_depth
    $error("kappa_mixer_chain: DEPTH must be in 2..16");
  end

  logic [WIDTH-1:0]         buf_q [DEPTH];
  logic [WIDTH-1:0]         buf_d [DEPTH];
  logic [WIDTH-1:0]         mixed;
  logic [WIDTH-1:0]         out_data_q;
  logic                     out_valid_q;
  logic [CNT_W-1:0]         beat_cnt_q;
  logic                     primed_q;
  logic [KAPPA_PRIME_W-1:0] prime_cnt_q;
  logic                     accept;

  assign in_ready = rst_n && !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  kappa_combine #(
    .WIDTH (WIDTH)
  ) u_combine (
    .a    (buf_q[DEPTH-2]),
    .b    (buf_q[DEPTH-1]),
    .mode (kappa_mode_e'(mode)),
    .y    (mixed)
  );

  assign buf_d[0] = z_in + mixed;
  for (genvar i = 1; i < DEPTH; i++) begin : g_stage
    assign buf_d[i] = buf_q[i-1] | z_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= buf_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_data_q  <= mixed ^ z_in;
      out_valid_q <= 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // primed tracks its own saturating count so a narrow beat_cnt cannot hide it.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      beat_cnt_q  <= '0;
      prime_cnt_q <= '0;
      primed_q    <= 1'b0;
    end else if (accept) begin
      beat_cnt_q <= beat_cnt_q + CNT_W'(1);
      if (!primed_q) begin
        prime_cnt_q <= prime_cnt_q + KAPPA_PRIME_W'(1);
        if (prime_cnt_q == KAPPA_PRIME_W'(DEPTH - 1)) primed_q <= 1'b1;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign beat_cnt  = beat_cnt_q;
  assign primed    = primed_q;

endmodule

// File: tb/tb_kappa_mixer_chain.sv
// Directed bench: legacy vectors, flush/replay, backpressure, depth 3, narrow counter, sync reset.
module tb_kappa_mixer_chain;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       out_ready;
  logic [7:0] z;
  logic [1:0] mode;
  logic       in_valid_a, in_valid_b, in_valid_c;

  logic        in_ready_a, out_valid_a, primed_a;
  logic [7:0]  out_data_a;
  logic [15:0] beat_cnt_a;
  logic        in_ready_b, out_valid_b, primed_b;
  logic [7:0]  out_data_b;
  logic [15:0] beat_cnt_b;
  logic        in_ready_c, out_valid_c, primed_c;
  logic [7:0]  out_data_c;
  logic [3:0]  beat_cnt_c;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  kappa_mixer_chain #(.WIDTH(8), .DEPTH(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a), .z_in(z),
    .mode(mode), .flush(flush), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_data(out_data_a), .beat_cnt(beat_cnt_a), .primed(primed_a)
  );

  kappa_mixer_chain #(.WIDTH(8), .DEPTH(3), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b), .z_in(z),
    .mode(mode), .flush(flush), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_data(out_data_b), .beat_cnt(beat_cnt_b), .primed(primed_b)
  );

  kappa_mixer_chain #(.WIDTH(8), .DEPTH(2), .CNT_W(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_c), .in_ready(in_ready_c), .z_in(z),
    .mode(mode), .flush(flush), .out_valid(out_valid_c), .out_ready(out_ready),
    .out_data(out_data_c), .beat_cnt(beat_cnt_c), .primed(primed_c)
  );

  typedef struct {
    logic [7:0]  z;
    logic [1:0]  mode;
    logic        flush_before;
    logic [7:0]  exp_out;
    logic [7:0]  exp_b0;
    logic [7:0]  exp_b1;
    logic [15:0] exp_cnt;
    logic        exp_primed;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{8'h01, 2'd0, 1'b0, 8'h01, 8'h01, 8'h01, 16'd1, 1'b0};
    vecs[1] = '{8'h02, 2'd0, 1'b0, 8'h03, 8'h03, 8'h03, 16'd2, 1'b1};
    vecs[2] = '{8'h03, 2'd0, 1'b0, 8'h00, 8'h06, 8'h03, 16'd3, 1'b1};
    // Replay after flush with the reserved mode: must match the AND results.
    vecs[3] = '{8'h01, 2'd3, 1'b1, 8'h01, 8'h01, 8'h01, 16'd1, 1'b0};
    vecs[4] = '{8'h02, 2'd3, 1'b0, 8'h03, 8'h03, 8'h03, 16'd2, 1'b1};
    vecs[5] = '{8'h03, 2'd3, 1'b0, 8'h00, 8'h06, 8'h03, 16'd3, 1'b1};
    vecs[6] = '{8'h10, 2'd2, 1'b0, 8'h15, 8'h15, 8'h16, 16'd4, 1'b1};
    vecs[7] = '{8'h80, 2'd1, 1'b0, 8'h97, 8'h97, 8'h95, 16'd5, 1'b1};
    vecs[8] = '{8'hF0, 2'd0, 1'b0, 8'h65, 8'h85, 8'hF7, 16'd6, 1'b1};

    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; z = '0; mode = 2'd0;
    in_valid_a = 1'b0; in_valid_b = 1'b0; in_valid_c = 1'b0;
    repeat (2) tick();
    in_valid_a = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready_a), 32'd0);
    chk("rst_out_valid", 32'(out_valid_a), 32'd0);
    chk("rst_out_data", 32'(out_data_a), 32'd0);
    chk("rst_beat_cnt", 32'(beat_cnt_a), 32'd0);
    chk("rst_primed", 32'(primed_a), 32'd0);
    in_valid_a = 1'b0;
    rst_n = 1'b1;
    tick();

    // Table-driven beats on the DEPTH=2 instance.
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].flush_before) begin
        flush = 1'b1; in_valid_a = 1'b1; z = 8'h77;
        #1;
        chk("flush_in_ready", 32'(in_ready_a), 32'd0);
        tick();
        flush = 1'b0; in_valid_a = 1'b0;
        chk("flush_out_valid", 32'(out_valid_a), 32'd0);
        chk("flush_beat_cnt", 32'(beat_cnt_a), 32'd0);
        chk("flush_primed", 32'(primed_a), 32'd0);
        chk("flush_buf0", 32'(dut_a.buf_q[0]), 32'd0);
      end
      z = vecs[i].z; mode = vecs[i].mode; in_valid_a = 1'b1;
      #1;
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready_a), 32'd1);
      tick();
      in_valid_a = 1'b0;
      chk($sformatf("vec%0d_out_data", i), 32'(out_data_a), 32'(vecs[i].exp_out));
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid_a), 32'd1);
      chk($sformatf("vec%0d_buf0", i), 32'(dut_a.buf_q[0]), 32'(vecs[i].exp_b0));
      chk($sformatf("vec%0d_buf1", i), 32'(dut_a.buf_q[1]), 32'(vecs[i].exp_b1));
      chk($sformatf("vec%0d_beat_cnt", i), 32'(beat_cnt_a), 32'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d_primed", i), 32'(primed_a), 32'(vecs[i].exp_primed));
    end
    tick();
    chk("drain_out_valid", 32'(out_valid_a), 32'd0);

    // Backpressure on a freshly flushed chain.
    flush = 1'b1; tick(); flush = 1'b0;
    out_ready = 1'b0; mode = 2'd0; z = 8'h05; in_valid_a = 1'b1;
    tick();
    z = 8'h09;
    #1;
    chk("bp_out_valid", 32'(out_valid_a), 32'd1);
    chk("bp_in_ready", 32'(in_ready_a), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("bp_hold%0d_data", k), 32'(out_data_a), 32'h05);
      chk($sformatf("bp_hold%0d_valid", k), 32'(out_valid_a), 32'd1);
      chk($sformatf("bp_hold%0d_buf0", k), 32'(dut_a.buf_q[0]), 32'h05);
      chk($sformatf("bp_hold%0d_buf1", k), 32'(dut_a.buf_q[1]), 32'h05);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(in_ready_a), 32'd1);
    tick();
    in_valid_a = 1'b0;
    chk("bp_next_data", 32'(out_data_a), 32'h0C);
    chk("bp_next_valid", 32'(out_valid_a), 32'd1);
    chk("bp_beat_cnt", 32'(beat_cnt_a), 32'd2);
    chk("bp_buf0", 32'(dut_a.buf_q[0]), 32'h0E);
    chk("bp_buf1", 32'(dut_a.buf_q[1]), 32'h0D);
    tick();
    chk("bp_drain_valid", 32'(out_valid_a), 32'd0);

    // DEPTH=3 instance, OR mode.
    mode = 2'd1;
    z = 8'h01; in_valid_b = 1'b1; tick();
    chk("d3_b1_data", 32'(out_data_b), 32'h01);
    chk("d3_b1_primed", 32'(primed_b), 32'd0);
    z = 8'h02; tick();
    chk("d3_b2_data", 32'(out_data_b), 32'h03);
    chk("d3_b2_primed", 32'(primed_b), 32'd0);
    chk("d3_buf0", 32'(dut_b.buf_q[0]), 32'h03);
    chk("d3_buf1", 32'(dut_b.buf_q[1]), 32'h03);
    chk("d3_buf2", 32'(dut_b.buf_q[2]), 32'h03);
    z = 8'h04; tick();
    in_valid_b = 1'b0;
    chk("d3_b3_data", 32'(out_data_b), 32'h07);
    chk("d3_b3_primed", 32'(primed_b), 32'd1);
    chk("d3_b3_cnt", 32'(beat_cnt_b), 32'd3);

    // CNT_W=4 instance: 17 back-to-back beats wrap the counter but keep primed.
    mode = 2'd0; in_valid_c = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      z = 8'(k);
      tick();
      if (k == 16) begin
        chk("c4_wrap_cnt", 32'(beat_cnt_c), 32'd0);
        chk("c4_wrap_primed", 32'(primed_c), 32'd1);
      end
    end
    in_valid_c = 1'b0;
    chk("c4_cnt17", 32'(beat_cnt_c), 32'd1);
    chk("c4_primed17", 32'(primed_c), 32'd1);

    // Synchronous reset: held output, then reset lands only at the next posedge.
    out_ready = 1'b0; mode = 2'd0; z = 8'h42; in_valid_a = 1'b1;
    tick();
    in_valid_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b0; out_ready = 1'b1;
    #1;
    chk("srst_pre_valid", 32'(out_valid_a), 32'd1);
    chk("srst_pre_data", 32'(out_data_a), 32'h4E);
    chk("srst_pre_cnt", 32'(beat_cnt_a), 32'd3);
    chk("srst_in_ready_low", 32'(in_ready_a), 32'd0);
    tick();
    chk("srst_valid", 32'(out_valid_a), 32'd0);
    chk("srst_data", 32'(out_data_a), 32'd0);
    chk("srst_cnt", 32'(beat_cnt_a), 32'd0);
    chk("srst_buf0", 32'(dut_a.buf_q[0]), 32'd0);
    chk("srst_c_cnt", 32'(beat_cnt_c), 32'd0);
    chk("srst_c_primed", 32'(primed_c), 32'd0);
    chk("srst_in_ready", 32'(in_ready_a), 32'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
